// File: rtl/jpegls_run_pkg.sv
// Shared constants for the JPEG-LS run-mode coder and decoder.
// J table, FSM encoding and default widths.
package jpegls_run_pkg;

    localparam int RUNCOUNT_LENGTH = 16;
    localparam int RUNINDEX_LENGTH = 5;
    localparam int J_LENGTH        = 4;
    localparam int CODE_LENGTH     = 16;

    localparam int RUNINDEX_MAX = 31;

    localparam logic [0:31][3:0] J_TABLE = {
        4'd0,  4'd0,  4'd0,  4'd0,
        4'd1,  4'd1,  4'd1,  4'd1,
        4'd2,  4'd2,  4'd2,  4'd2,
        4'd3,  4'd3,  4'd3,  4'd3,
        4'd4,  4'd4,  4'd5,  4'd5,
        4'd6,  4'd6,  4'd7,  4'd7,
        4'd8,  4'd9,  4'd10, 4'd11,
        4'd12, 4'd13, 4'd14, 4'd15
    };

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_SEG    = 3'd1;
    localparam logic [2:0] ST_EOLBIT = 3'd2;
    localparam logic [2:0] ST_TAIL   = 3'd3;
    localparam logic [2:0] ST_DONE   = 3'd4;

endpackage

// File: rtl/run_j_lookup.sv
// run_index to J and segment threshold (1 << J).
// Purely combinational; shared with the run-mode decoder.
module run_j_lookup
    import jpegls_run_pkg::*;
#(
    parameter int runindex_length = RUNINDEX_LENGTH,
    parameter int J_length        = J_LENGTH,
    parameter int thr_length      = RUNCOUNT_LENGTH
) (
    input  logic [runindex_length-1:0] idx,
    output logic [J_length-1:0]        j,
    output logic [thr_length-1:0]      thr
);

    logic [3:0] j_raw;

    assign j_raw = J_TABLE[5'(idx)];
    assign j     = J_length'(j_raw);
    assign thr   = thr_length'(1) << j_raw;

endmodule

// File: rtl/run_mode_controller.sv
// Run-mode sequencer: walks the run_index/J recursion for one run and
// streams segment bits and the interruption tail to the bit writer.
module run_mode_controller
    import jpegls_run_pkg::*;
#(
    parameter int runcount_length = RUNCOUNT_LENGTH,
    parameter int runindex_length = RUNINDEX_LENGTH,
    parameter int J_length        = J_LENGTH,
    parameter int code_length     = CODE_LENGTH
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       scan_start,
    input  logic                       start,
    input  logic [runcount_length-1:0] run_len,
    input  logic                       eol,
    output logic                       busy,
    output logic                       bits_valid,
    input  logic                       out_ready,
    output logic [code_length-1:0]     bits,
    output logic [4:0]                 bits_len,
    output logic                       done,
    output logic [runindex_length-1:0] done_run_index,
    output logic [runindex_length-1:0] run_index,
    output logic [J_length-1:0]        J_out
);

    logic [2:0]                 state;
    logic [runcount_length-1:0] rem;
    logic                       eol_q;
    logic [J_length-1:0]        j;
    logic [runcount_length-1:0] thr;
    logic                       seg_hit;

    run_j_lookup #(
        .runindex_length(runindex_length),
        .J_length       (J_length),
        .thr_length     (runcount_length)
    ) u_lookup (
        .idx(run_index),
        .j  (j),
        .thr(thr)
    );

    assign seg_hit = (rem >= thr);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= ST_IDLE;
            rem            <= '0;
            eol_q          <= 1'b0;
            run_index      <= '0;
            done_run_index <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (scan_start)
                        run_index <= '0;
                    if (start) begin
                        rem   <= run_len;
                        eol_q <= eol;
                        state <= ST_SEG;
                    end
                end
                ST_SEG: begin
                    if (seg_hit) begin
                        if (out_ready) begin
                            rem <= rem - thr;
                            if (run_index != runindex_length'(RUNINDEX_MAX))
                                run_index <= run_index + runindex_length'(1);
                        end
                    end else if (eol_q && rem != '0) begin
                        state <= ST_EOLBIT;
                    end else if (eol_q) begin
                        done_run_index <= run_index;
                        state          <= ST_DONE;
                    end else begin
                        state <= ST_TAIL;
                    end
                end
                ST_EOLBIT: begin
                    if (out_ready) begin
                        done_run_index <= run_index;
                        state          <= ST_DONE;
                    end
                end
                ST_TAIL: begin
                    if (out_ready) begin
                        done_run_index <= run_index;
                        if (run_index != '0)
                            run_index <= run_index - runindex_length'(1);
                        state <= ST_DONE;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Codeword is a pure function of held state, so it stays stable under backpressure.
    always_comb begin
        bits_valid = 1'b0;
        bits       = '0;
        bits_len   = '0;
        case (state)
            ST_SEG: begin
                if (seg_hit) begin
                    bits_valid = 1'b1;
                    bits       = code_length'(1);
                    bits_len   = 5'd1;
                end
            end
            ST_EOLBIT: begin
                bits_valid = 1'b1;
                bits       = code_length'(1);
                bits_len   = 5'd1;
            end
            ST_TAIL: begin
                bits_valid = 1'b1;
                bits       = code_length'(rem & (thr - runcount_length'(1)));
                bits_len   = 5'(j) + 5'd1;
            end
            default: ;
        endcase
    end

    assign busy  = (state != ST_IDLE);
    assign done  = (state == ST_DONE);
    assign J_out = j;

endmodule

// File: tb/tb_run_mode_controller.sv
// Directed bench for run_mode_controller.
// Codewords are collected as {len, bits} and compared to hand values.
module tb_run_mode_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic        scan_start;
    logic        start;
    logic [15:0] run_len;
    logic        eol;
    logic        busy;
    logic        bits_valid;
    logic        out_ready;
    logic [15:0] bits;
    logic [4:0]  bits_len;
    logic        done;
    logic [4:0]  done_run_index;
    logic [4:0]  run_index;
    logic [3:0]  J_out;

    int checks = 0;
    int failures = 0;

    logic [20:0] words [$];
    logic [4:0]  got_dri;

    always #5 clk = ~clk;

    run_mode_controller dut (
        .clk           (clk),
        .reset         (reset),
        .scan_start    (scan_start),
        .start         (start),
        .run_len       (run_len),
        .eol           (eol),
        .busy          (busy),
        .bits_valid    (bits_valid),
        .out_ready     (out_ready),
        .bits          (bits),
        .bits_len      (bits_len),
        .done          (done),
        .done_run_index(done_run_index),
        .run_index     (run_index),
        .J_out         (J_out)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_valid"}, 32'(bits_valid), 0);
        check({tag, "_bits"}, 32'(bits), 0);
        check({tag, "_len"}, 32'(bits_len), 0);
        check({tag, "_done"}, 32'(done), 0);
        check({tag, "_dri"}, 32'(done_run_index), 0);
        check({tag, "_ri"}, 32'(run_index), 0);
    endtask

    // Runs one coded run; optionally stalls word hold_word for hold_n cycles
    // and pokes start/scan_start while busy.
    task automatic do_run(input logic [15:0] len, input logic e,
                          input logic sc, input int hold_word,
                          input int hold_n, input logic poke);
        int held;
        logic seen;
        logic [15:0] hb;
        logic [4:0] hl;
        logic [4:0] hri;
        words.delete();
        held = 0;
        seen = 1'b0;
        hb = '0;
        hl = '0;
        hri = '0;
        @(negedge clk);
        start = 1'b1;
        run_len = len;
        eol = e;
        scan_start = sc;
        out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        scan_start = 1'b0;
        for (int cyc = 0; cyc < 200 && !seen; cyc++) begin
            if (poke) begin
                start = (cyc == 0);
                scan_start = (cyc == 0);
                run_len = 16'd7;
            end
            if (done) begin
                seen = 1'b1;
                got_dri = done_run_index;
            end else if (bits_valid && words.size() == hold_word
                         && held < hold_n) begin
                if (held == 0) begin
                    hb = bits;
                    hl = bits_len;
                    hri = run_index;
                end else begin
                    check("hold_bits", 32'(bits), 32'(hb));
                    check("hold_len", 32'(bits_len), 32'(hl));
                    check("hold_ri", 32'(run_index), 32'(hri));
                end
                out_ready = 1'b0;
                held++;
            end else begin
                out_ready = 1'b1;
                if (bits_valid)
                    words.push_back({bits_len, bits});
            end
            @(negedge clk);
        end
        start = 1'b0;
        scan_start = 1'b0;
        out_ready = 1'b1;
        check("done_seen", 32'(seen), 1);
        check("done_pulse", 32'(done), 0);
        check("back_idle", 32'(busy), 0);
    endtask

    initial begin
        int ones;
        reset = 1'b1;
        scan_start = 1'b0;
        start = 1'b0;
        run_len = '0;
        eol = 1'b0;
        out_ready = 1'b1;
        got_dri = '0;
        repeat (3) @(negedge clk);
        check_idle_outputs("rst");
        reset = 1'b0;
        @(negedge clk);
        check_idle_outputs("post_rst");

        // run_len=5, eol=0, with stall on word 1 and ignored pokes
        do_run(16'd5, 1'b0, 1'b1, 1, 3, 1'b1);
        check("r5_count", 32'(words.size()), 5);
        for (int i = 0; i < 4 && i < words.size(); i++)
            check("r5_seg", 32'(words[i]), 32'({5'd1, 16'd1}));
        if (words.size() == 5)
            check("r5_tail", 32'(words[4]), 32'({5'd2, 16'd1}));
        check("r5_dri", 32'(got_dri), 4);
        check("r5_ri", 32'(run_index), 3);
        check("r5_j", 32'(J_out), 0);

        // bring run_index to 4, then eol runs
        do_run(16'd4, 1'b1, 1'b1, -1, 0, 1'b0);
        check("r4e_count", 32'(words.size()), 4);
        check("r4e_ri", 32'(run_index), 4);
        check("r4e_j", 32'(J_out), 1);
        do_run(16'd3, 1'b1, 1'b0, -1, 0, 1'b0);
        check("r3e_count", 32'(words.size()), 2);
        if (words.size() == 2) begin
            check("r3e_w0", 32'(words[0]), 32'({5'd1, 16'd1}));
            check("r3e_eol", 32'(words[1]), 32'({5'd1, 16'd1}));
        end
        check("r3e_dri", 32'(got_dri), 5);
        check("r3e_ri", 32'(run_index), 5);
        do_run(16'd0, 1'b1, 1'b0, -1, 0, 1'b0);
        check("r0e_count", 32'(words.size()), 0);
        check("r0e_dri", 32'(got_dri), 5);
        check("r0e_ri", 32'(run_index), 5);

        // saturation
        do_run(16'd33052, 1'b1, 1'b1, -1, 0, 1'b0);
        check("sat_count", 32'(words.size()), 31);
        ones = 0;
        foreach (words[i])
            if (words[i] == {5'd1, 16'd1})
                ones++;
        check("sat_ones", 32'(ones), 31);
        check("sat_ri", 32'(run_index), 31);
        check("sat_j", 32'(J_out), 15);
        check("sat_dri", 32'(got_dri), 31);
        do_run(16'd40000, 1'b0, 1'b0, -1, 0, 1'b0);
        check("big_count", 32'(words.size()), 2);
        if (words.size() == 2) begin
            check("big_seg", 32'(words[0]), 32'({5'd1, 16'd1}));
            check("big_tail", 32'(words[1]), 32'({5'd16, 16'd7232}));
        end
        check("big_dri", 32'(got_dri), 31);
        check("big_ri", 32'(run_index), 30);

        // zero run at index 0, interruption
        do_run(16'd0, 1'b0, 1'b1, -1, 0, 1'b0);
        check("z_count", 32'(words.size()), 1);
        if (words.size() == 1)
            check("z_tail", 32'(words[0]), 32'({5'd1, 16'd0}));
        check("z_dri", 32'(got_dri), 0);
        check("z_ri", 32'(run_index), 0);

        // reset in the middle of a long run
        @(negedge clk);
        start = 1'b1;
        run_len = 16'd100;
        eol = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("mid_busy", 32'(busy), 1);
        check("mid_ri", 32'(run_index), 3);
        reset = 1'b1;
        #1;
        check_idle_outputs("mid_rst");
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_idle_outputs("after_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
